// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - requester, response and ALU-side signal bundle for alu_share_arb
//
// Purpose: groups the two requester request channels, the two response
// channels and the ALU operand/result signals into one interface.
//   slave  : used by alu_share_arb (takes requests and ALU results, drives
//            grants, responses and ALU operands)
//   master : used by the surrounding logic (requesters plus the ALU itself)
// Parameters: DATA_W operand/result width, CTRL_W ALU control code width.

interface alu_share_arb_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);

  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [DATA_W-1:0] req0_src1_i;
  logic [DATA_W-1:0] req0_src2_i;
  logic [CTRL_W-1:0] req0_ctrl_i;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [DATA_W-1:0] req1_src1_i;
  logic [DATA_W-1:0] req1_src2_i;
  logic [CTRL_W-1:0] req1_ctrl_i;

  logic              resp0_valid_o;
  logic              resp0_ready_i;
  logic              resp1_valid_o;
  logic              resp1_ready_i;
  logic [DATA_W-1:0] resp_data_o;
  logic              resp_zero_o;
  logic              resp_err_o;

  logic [DATA_W-1:0] alu_src1_o;
  logic [DATA_W-1:0] alu_src2_o;
  logic [CTRL_W-1:0] alu_ctrl_o;
  logic [DATA_W-1:0] alu_result_i;
  logic              alu_zero_i;

  modport slave (
    input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    output req0_ready_o, req1_ready_o,
    output resp0_valid_o, resp1_valid_o,
    input  resp0_ready_i, resp1_ready_i,
    output resp_data_o, resp_zero_o, resp_err_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  alu_result_i, alu_zero_i
  );

  modport master (
    output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    input  req0_ready_o, req1_ready_o,
    input  resp0_valid_o, resp1_valid_o,
    output resp0_ready_i, resp1_ready_i,
    input  resp_data_o, resp_zero_o, resp_err_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o,
    output alu_result_i, alu_zero_i
  );

endinterface

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one combinational ALU between two requesters
//
// Purpose: arbitrates two requesters onto a single ALU, registers the granted
// operands, captures the ALU result after one full cycle and returns it to the
// granted requester over a valid/ready response handshake.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - alu_share_arb_if.slave: req0/req1 valid/ready/src1/src2/ctrl,
//            resp0/resp1 valid/ready, shared resp_data/zero/err,
//            alu_src1/src2/ctrl out, alu_result/zero in
// Optional feature macro: ALU_ILLEGAL_OP_CHK_EN
//   defined   - ops with a ctrl code outside the legal set bypass the ALU and
//               answer one cycle early with data=0, zero=0, err=1
//   undefined - every ctrl code goes to the ALU, resp_err_o is constant 0

module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_share_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  logic [1:0]        resp_valid_q, resp_valid_d;

  logic              win0, win1;
  logic [DATA_W-1:0] sel_src1, sel_src2;
  logic [CTRL_W-1:0] sel_ctrl;
  logic              granted_ready;

`ifdef ALU_ILLEGAL_OP_CHK_EN
  function automatic logic is_illegal(input logic [CTRL_W-1:0] c);
    return !(c == CTRL_W'(4'b0000) || c == CTRL_W'(4'b0001) ||
             c == CTRL_W'(4'b0010) || c == CTRL_W'(4'b0110) ||
             c == CTRL_W'(4'b0111) || c == CTRL_W'(4'b1000) ||
             c == CTRL_W'(4'b1001) || c == CTRL_W'(4'b1011));
  endfunction
`endif

  // On a tie the requester that was not served last wins; at most one of
  // win0/win1 is ever high.
  assign win0 = bus.req0_valid_i && (!bus.req1_valid_i || last_grant_q);
  assign win1 = bus.req1_valid_i && (!bus.req0_valid_i || !last_grant_q);

  assign sel_src1 = win1 ? bus.req1_src1_i : bus.req0_src1_i;
  assign sel_src2 = win1 ? bus.req1_src2_i : bus.req0_src2_i;
  assign sel_ctrl = win1 ? bus.req1_ctrl_i : bus.req0_ctrl_i;

  assign granted_ready = grant_q ? bus.resp1_ready_i : bus.resp0_ready_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    zero_d       = zero_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (win0 || win1) begin
          grant_d = win1;
          src1_d  = sel_src1;
          src2_d  = sel_src2;
`ifdef ALU_ILLEGAL_OP_CHK_EN
          if (is_illegal(sel_ctrl)) begin
            // ALU is bypassed, so its control register keeps the last legal code.
            data_d       = '0;
            zero_d       = 1'b0;
            err_d        = 1'b1;
            resp_valid_d = win1 ? 2'b10 : 2'b01;
            state_d      = ST_RESP;
          end else begin
            ctrl_d  = sel_ctrl;
            state_d = ST_EXEC;
          end
`else
          ctrl_d  = sel_ctrl;
          state_d = ST_EXEC;
`endif
        end
      end

      ST_EXEC: begin
        data_d       = bus.alu_result_i;
        zero_d       = bus.alu_zero_i;
        err_d        = 1'b0;
        resp_valid_d = grant_q ? 2'b10 : 2'b01;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        if (granted_ready) begin
          resp_valid_d = 2'b00;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        resp_valid_d = 2'b00;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      ctrl_q       <= '0;
      data_q       <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req0_ready_o  = (state_q == ST_IDLE) && win0;
  assign bus.req1_ready_o  = (state_q == ST_IDLE) && win1;
  assign bus.resp0_valid_o = resp_valid_q[0];
  assign bus.resp1_valid_o = resp_valid_q[1];
  assign bus.resp_data_o   = data_q;
  assign bus.resp_zero_o   = zero_q;
  assign bus.resp_err_o    = err_q;
  assign bus.alu_src1_o    = src1_q;
  assign bus.alu_src2_o    = src2_q;
  assign bus.alu_ctrl_o    = ctrl_q;

endmodule
